// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the round-robin adder-sharing block.
package adder_share_pkg;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  // Wraps explicitly at nreq-1 so non-power-of-two requester counts work.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
    return (ptr >= nreq - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Combinational WIDTH-bit adder built from generate/propagate terms.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carry;
  logic             cy;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each carry is a flat function of g/p terms once synthesis unrolls the loop.
  always_comb begin
    carry = '0;
    cy    = c_i;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = cy;
      cy       = gen[i] | (prop[i] & cy);
    end
    c_o = cy;
  end

  assign sum_o = prop ^ carry;

endmodule

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_arbiter_pick #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] grantIdx_o,
  output logic            anyValid_o
);

  int              pos;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    found      = 1'b0;
    pos        = 0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = ID_W'(pos);
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grantIdx_o   = idx;
      end
    end
  end

  assign anyValid_o = |valid_i;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder among NREQ requesters, with a single-entry
// registered response stage that can drain and refill on the same edge.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [WIDTH:0]        o_rsp_result,
  input  logic                  i_rsp_ready,
  output logic [CNT_W-1:0]      o_op_count
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  rspId_q, rspId_d;
  logic [WIDTH:0]   rspResult_q, rspResult_d;
  logic [CNT_W-1:0] opCount_q, opCount_d;

  logic [NREQ-1:0]  grantOneHot;
  logic [ID_W-1:0]  grantIdx;
  logic             anyValid;
  logic             canAccept;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] sum;
  logic             cout;

  rr_arbiter_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .valid_i   (i_req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (grantOneHot),
    .grantIdx_o(grantIdx),
    .anyValid_o(anyValid)
  );

  assign opA = i_req_a[int'(grantIdx)*WIDTH +: WIDTH];
  assign opB = i_req_b[int'(grantIdx)*WIDTH +: WIDTH];

  carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i  (opA),
    .b_i  (opB),
    .c_i  (1'b0),
    .sum_o(sum),
    .c_o  (cout)
  );

  // The rsp_ready -> req_ready combinational path lets a full stage refill without a bubble.
  assign canAccept   = (state_q == ST_EMPTY) | i_rsp_ready;
  assign o_rsp_valid = (state_q == ST_FULL);

  always_comb begin
    o_req_ready = '0;
    if (!i_rst && anyValid && canAccept) o_req_ready = grantOneHot;
  end

  assign accept = |(i_req_valid & o_req_ready);
  assign drain  = o_rsp_valid & i_rsp_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rspId_d     = rspId_q;
    rspResult_d = rspResult_q;
    opCount_d   = opCount_q;
    if (accept) begin
      state_d     = ST_FULL;
      ptr_d       = ID_W'(rr_next(32'(grantIdx), NREQ));
      rspId_d     = grantIdx;
      rspResult_d = {cout, sum};
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
    if (drain) opCount_d = opCount_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      ptr_q       <= '0;
      rspId_q     <= '0;
      rspResult_q <= '0;
      opCount_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rspId_q     <= rspId_d;
      rspResult_q <= rspResult_d;
      opCount_q   <= opCount_d;
    end
  end

  assign o_rsp_id     = rspId_q;
  assign o_rsp_result = rspResult_q;
  assign o_op_count   = opCount_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench: a vector table on a 4-requester instance plus hand sequences
// on a 3-requester instance with a 4-bit counter for wrap behaviour.
module tb_adder_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4;
  logic [3:0]  valid4;
  logic [31:0] a4, b4;
  logic        rr4;
  logic [3:0]  ready4;
  logic        rspValid4;
  logic [1:0]  id4;
  logic [8:0]  res4;
  logic [15:0] cnt4;

  logic        rst3;
  logic [2:0]  valid3;
  logic [23:0] a3, b3;
  logic        rr3;
  logic [2:0]  ready3;
  logic        rspValid3;
  logic [1:0]  id3;
  logic [8:0]  res3;
  logic [3:0]  cnt3;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.WIDTH(8), .NREQ(4), .CNT_W(16)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_req_valid(valid4), .i_req_a(a4), .i_req_b(b4),
    .o_req_ready(ready4), .o_rsp_valid(rspValid4), .o_rsp_id(id4),
    .o_rsp_result(res4), .i_rsp_ready(rr4), .o_op_count(cnt4)
  );

  adder_share_arbiter #(.WIDTH(8), .NREQ(3), .CNT_W(4)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req_valid(valid3), .i_req_a(a3), .i_req_b(b3),
    .o_req_ready(ready3), .o_rsp_valid(rspValid3), .o_rsp_id(id3),
    .o_rsp_result(res3), .i_rsp_ready(rr3), .o_op_count(cnt3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        rspReady;
    logic [3:0]  expReady;
    logic        expValid;
    logic [1:0]  expId;
    logic [8:0]  expResult;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs[$];
  logic [8:0] exp3 [3];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one table row, checks same-cycle ready, then the registered outputs after the edge.
  task automatic applyStimulus(input vec_t v, input int n);
    rst4   = v.rst;
    valid4 = v.valid;
    rr4    = v.rspReady;
    #1;
    checkOutput($sformatf("v%0d ready", n), 32'(ready4), 32'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d rsp_valid", n), 32'(rspValid4), 32'(v.expValid));
    if (v.expValid || v.rst) begin
      checkOutput($sformatf("v%0d rsp_id", n), 32'(id4), 32'(v.expId));
      checkOutput($sformatf("v%0d result", n), 32'(res4), 32'(v.expResult));
    end
    checkOutput($sformatf("v%0d op_count", n), 32'(cnt4), 32'(v.expCount));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Operands per requester (k3..k0): sums 1FE, 0FF, 100, 015.
    a4 = {8'hFF, 8'h7F, 8'hFF, 8'h10};
    b4 = {8'hFF, 8'h80, 8'h01, 8'h05};
    // Sums for k2..k0: 0FF, 1FE, 003.
    a3 = {8'h80, 8'hFF, 8'h01};
    b3 = {8'h7F, 8'hFF, 8'h02};
    exp3[0] = 9'h003;
    exp3[1] = 9'h1FE;
    exp3[2] = 9'h0FF;
    rst3 = 1'b1;
    valid3 = 3'b000;
    rr3 = 1'b0;

    //               rst   valid    rr    expRdy   eV    id    result   count
    vecs.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 16'd0});
    vecs.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 16'd0});
    vecs.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 9'h100, 16'd0});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h0FF, 16'd1});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h1FE, 16'd2});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h015, 16'd3});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 9'h100, 16'd4});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h0FF, 16'd5});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h1FE, 16'd6});
    vecs.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h015, 16'd7});
    vecs.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 9'h015, 16'd7});
    vecs.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 9'h015, 16'd7});
    vecs.push_back('{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 9'h015, 16'd7});
    vecs.push_back('{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 9'h100, 16'd8});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 16'd9});
    vecs.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h0FF, 16'd9});
    vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h1FE, 16'd10});
    vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h015, 16'd11});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 9'h015, 16'd11});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 16'd12});
    vecs.push_back('{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h1FE, 16'd12});
    vecs.push_back('{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h1FE, 16'd13});
    vecs.push_back('{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h1FE, 16'd14});
    vecs.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h015, 16'd15});
    vecs.push_back('{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 16'd0});
    vecs.push_back('{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 16'd0});
    vecs.push_back('{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h015, 16'd0});
    vecs.push_back('{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h0FF, 16'd1});

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Three requesters: order 0,1,2,0,... and the 4-bit counter wrapping after 16.
    rst3 = 1'b1;
    valid3 = 3'b111;
    rr3 = 1'b1;
    #1;
    checkOutput("n3 reset ready", 32'(ready3), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("n3 reset rsp_valid", 32'(rspValid3), 32'd0);
    checkOutput("n3 reset op_count", 32'(cnt3), 32'd0);

    for (int i = 0; i < 18; i++) begin
      rst3 = 1'b0;
      valid3 = 3'b111;
      rr3 = 1'b1;
      #1;
      checkOutput($sformatf("n3 step%0d ready", i), 32'(ready3), 32'(3'b001 << (i % 3)));
      @(posedge clk);
      #1;
      checkOutput($sformatf("n3 step%0d rsp_valid", i), 32'(rspValid3), 32'd1);
      checkOutput($sformatf("n3 step%0d rsp_id", i), 32'(id3), 32'(i % 3));
      checkOutput($sformatf("n3 step%0d result", i), 32'(res3), 32'(exp3[i % 3]));
      checkOutput($sformatf("n3 step%0d op_count", i), 32'(cnt3), 32'(i % 16));
    end

    valid3 = 3'b000;
    rr3 = 1'b1;
    #1;
    checkOutput("n3 idle ready", 32'(ready3), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("n3 final rsp_valid", 32'(rspValid3), 32'd0);
    checkOutput("n3 final op_count", 32'(cnt3), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational carry_lookahead_adder among NREQ requesters.
- Round-robin arbitration selects one requester per cycle. Its operand pair drives the adder.
- The sum is captured in a single-entry registered response stage with a valid/ready handshake.
- Sits between multiple datapath clients and one adder instance, so one adder's area serves several producers.

Parameters:
- WIDTH, 8, operand width in bits; the result is WIDTH+1 bits.
- NREQ, 4, number of requesters; must be 2 or more.
- CNT_W, 16, width of the completed-operation counter.
- ID_W, derived as $clog2(NREQ), width of the requester index. Localparam, not overridable.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_a  in  NREQ*WIDTH  operand A, flattened; requester k occupies [k*WIDTH +: WIDTH].
- i_req_b  in  NREQ*WIDTH  operand B, same packing as i_req_a.
- o_req_ready  out  NREQ  one-hot or zero; the request is accepted when valid and ready are both high.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  ID_W  index of the requester that owns the response.
- o_rsp_result  out  WIDTH+1  A+B with carry-out in the MSB.
- i_rsp_ready  in  1  consumer accepts the response.
- o_op_count  out  CNT_W  number of responses consumed since reset; wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Values while and after reset:
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_op_count=0.
  - Round-robin pointer ptr=0; state EMPTY.
  - o_req_ready=0 while i_rst is high.
- Output stage FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on (o_rsp_valid & i_rsp_ready & no accept).
  - FULL -> FULL on (drain & accept): simultaneous drain and refill, no bubble.
- can_accept = (state==EMPTY) | i_rsp_ready. This is a combinational path from i_rsp_ready to o_req_ready, and it is intentional.
- Arbitration (combinational):
  - Scan i_req_valid starting at index ptr, ascending, wrapping at NREQ-1 -> 0. The first valid index is grant g.
  - o_req_ready[g] = can_accept. All other ready bits are 0.
  - If no requester is valid, all ready bits are 0.
- Accept: any k with i_req_valid[k] & o_req_ready[k].
  - The adder is fed the operands of g.
  - On the next edge: o_rsp_result <= sum, o_rsp_id <= g, o_rsp_valid <= 1, ptr <= (g+1) mod NREQ.
  - Latency: accept edge to o_rsp_valid high is 1 cycle.
- ptr changes only on accept. Stalls and idle cycles leave it unchanged.
- Requester rules: once valid is asserted, the requester holds valid, A and B stable until accepted. Validity does not depend on ready.
- Response rules: while o_rsp_valid=1 and i_rsp_ready=0, o_rsp_id and o_rsp_result stay stable.
- o_op_count increments by 1 on each response handshake (o_rsp_valid & i_rsp_ready). It wraps all-ones -> 0.
- Arithmetic: unsigned. The adder is invoked with carry-in 0. Result = {carry, sum}; no overflow is possible.
- Boundary conditions:
  - Full with no drain: all o_req_ready=0 and requests wait.
  - A single valid requester is granted back-to-back every cycle.
  - Reset asserted mid-operation: a held response is discarded and pending requests are not accepted. No state survives the reset edge.
  - NREQ not a power of two: ptr wraps explicitly at NREQ-1, never via bit truncation.

Decomposition:
- Package adder_share_pkg:
  - state enum {ST_EMPTY, ST_FULL}.
  - Function rr_next(ptr, NREQ) for the wrapped increment.
- Sub-module rr_arbiter_pick (parameter NREQ):
  - Inputs: valid vector, ptr.
  - Outputs: one-hot grant, grant index, any_valid.
  - Purely combinational, reusable by other shared-resource blocks.
- Instantiate the existing carry_lookahead_adder (WIDTH) once, fed by muxed operands.

Test Plan:
1. Single request: after reset, req1 valid with a=0xFF, b=0x01, i_rsp_ready=1 -> o_req_ready=4'b0010 in the same cycle; next cycle o_rsp_valid=1, id=1, result=9'h100; ptr=2.
2. Fairness: all four requesters continuously valid, i_rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, one response per cycle; o_op_count=6 after 6 handshakes.
3. Backpressure: response id=0 held FULL with i_rsp_ready=0 for 3 cycles -> o_req_ready=0 and result/id stable throughout. Raise i_rsp_ready -> the drain and next accept (id=1) happen on the same edge with no bubble.
4. Wrap: with ptr=3, only req0 and req3 valid -> grant 3 then 0. A 5.3 equivalent with NREQ=3, all valid -> order 0,1,2,0.
5. Reset mid-operation: i_rst high while FULL and req2 pending -> next cycle o_rsp_valid=0, o_op_count=0, ptr=0, and req2 is not acknowledged while i_rst is high.
6. Counter wrap: CNT_W=4, 17 consumed responses -> o_op_count=1. Max operands a=b=0xFF -> result=9'h1FE.
